// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings,
// the default reset PC and a word-alignment helper.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_S_RST   = 2'd0,
    FETCH_S_FETCH = 2'd1,
    FETCH_S_EXEC  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: JR over J/JAL over taken branch over
// sequential, with all target arithmetic wrapping at 32 bits.
module fetch_next_pc
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [31:0] jr_target,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        branch_taken,
  output logic [31:0] next_pc
);

  logic [31:0] br_offset;
  logic        unused_bits;

  assign br_offset   = {{14{instr[15]}}, instr[15:0], 2'b00};
  // Opcode bits and the JR low bits never contribute to a target.
  assign unused_bits = ^{instr[31:26], jr_target[1:0]};

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg) begin
      next_pc = word_align(jr_target);
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + br_offset;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, req/ack fetch FSM and retired-instruction count.
// Define FETCH_DELAY_SLOT_EN to defer taken redirects by one (delay-slot) instruction.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic        stall,
  output logic [31:0] icount
);

  fetch_state_e state;
  logic [31:0]  next_pc;
  logic [31:0]  retire_pc;
  logic         retire;

  fetch_next_pc u_next_pc (
    .pc_plus4     (pc_plus4),
    .instr        (instr),
    .jr_target    (jr_target),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .branch_taken (branch_taken),
    .next_pc      (next_pc)
  );

  assign retire = (state == FETCH_S_EXEC) && !stall;

`ifdef FETCH_DELAY_SLOT_EN
  logic        pend;
  logic [31:0] pend_target;
  logic        redirect;

  assign redirect = jump | jump_reg | branch_taken;

  // A pending target wins over the delay-slot instruction's own redirects.
  always_comb begin
    retire_pc = next_pc;
    if (pend) begin
      retire_pc = pend_target;
    end else if (redirect) begin
      retire_pc = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= 1'b0;
      pend_target <= RESET_PC;
    end else if (retire) begin
      if (pend) begin
        pend <= 1'b0;
      end else if (redirect) begin
        pend        <= 1'b1;
        pend_target <= next_pc;
      end
    end
  end
`else
  assign retire_pc = next_pc;
`endif

  // imem_addr doubles as the fetch PC; pc tracks the address of the held instr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_S_RST;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      pc          <= RESET_PC;
      pc_plus4    <= RESET_PC + 32'd4;
      icount      <= 32'h0;
    end else begin
      unique case (state)
        FETCH_S_RST: begin
          state    <= FETCH_S_FETCH;
          imem_req <= 1'b1;
        end
        FETCH_S_FETCH: begin
          if (imem_ack) begin
            state       <= FETCH_S_EXEC;
            imem_req    <= 1'b0;
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            pc          <= imem_addr;
            pc_plus4    <= imem_addr + 32'd4;
          end
        end
        FETCH_S_EXEC: begin
          if (retire) begin
            state       <= FETCH_S_FETCH;
            imem_req    <= 1'b1;
            imem_addr   <= retire_pc;
            instr_valid <= 1'b0;
            icount      <= icount + 32'd1;
          end
        end
        default: begin
          state    <= FETCH_S_RST;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; expectations are hand-computed
// and follow FETCH_DELAY_SLOT_EN when it is defined.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        jump = 1'b0;
  logic        jump_reg = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic        branch_taken = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] icount;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_icount = 32'h0;

  instr_fetch #(
    .RESET_PC (RST_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .jr_target    (jr_target),
    .branch_taken (branch_taken),
    .stall        (stall),
    .icount       (icount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ":req"},   {31'b0, imem_req},    32'd0);
    check({tag, ":addr"},  imem_addr,            RST_PC);
    check({tag, ":instr"}, instr,                32'h0);
    check({tag, ":valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, ":pc"},    pc,                   RST_PC);
    check({tag, ":pc4"},   pc_plus4,             RST_PC + 32'd4);
    check({tag, ":icnt"},  icount,               32'h0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    exp_icount = 32'h0;
  endtask

  // One instruction: fetch at exp_addr with same-cycle ack, then retire with the given redirects.
  task automatic step(input string tag, input logic [31:0] exp_addr, input logic [31:0] rdata,
                      input logic j, input logic jr, input logic br, input logic [31:0] jrt);
    int n = 0;
    while (imem_req !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":req"},  {31'b0, imem_req}, 32'd1);
    check({tag, ":addr"}, imem_addr, exp_addr);
    imem_ack = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_ack = 1'b0;
    check({tag, ":valid"}, {31'b0, instr_valid}, 32'd1);
    check({tag, ":instr"}, instr, rdata);
    check({tag, ":pc"},    pc, exp_addr);
    check({tag, ":pc4"},   pc_plus4, exp_addr + 32'd4);
    check({tag, ":icnt"},  icount, exp_icount);
    jump = j;
    jump_reg = jr;
    branch_taken = br;
    jr_target = jrt;
    @(negedge clk);
    jump = 1'b0;
    jump_reg = 1'b0;
    branch_taken = 1'b0;
    exp_icount++;
  endtask

  // Delay-slot instruction; its own jump (to 0) must be ignored.
  task automatic dslot(input string tag, input logic [31:0] exp_addr);
`ifdef FETCH_DELAY_SLOT_EN
    step(tag, exp_addr, 32'h0800_0000, 1'b1, 1'b0, 1'b0, 32'h0);
`else
    if (tag.len() == 0 || exp_addr == 32'h1) begin
      $display("unexpected empty delay-slot tag");
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset_dut();

    // Sequential fetch
    step("seq0", 32'h0040_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    step("seq1", 32'h0040_0004, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    step("seq2", 32'h0040_0008, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    check("seq:icnt3", icount, 32'd3);
    check("seq:addr3", imem_addr, 32'h0040_000C);

    // J / BEQ / JR redirects
    reset_dut();
    step("j",     32'h0040_0000, 32'h0810_0010, 1'b1, 1'b0, 1'b0, 32'h0);
    dslot("j_ds", 32'h0040_0004);
    step("j2",    32'h0040_0040, 32'h0810_0004, 1'b1, 1'b0, 1'b0, 32'h0);
    dslot("j2_ds", 32'h0040_0044);
    step("beq_t", 32'h0040_0010, 32'h1000_FFFF, 1'b0, 1'b0, 1'b1, 32'h0);
    dslot("beq_ds", 32'h0040_0014);
    step("beq_n", 32'h0040_0010, 32'h1000_FFFF, 1'b0, 1'b0, 1'b0, 32'h0);
    step("jr",    32'h0040_0014, 32'h0810_0010, 1'b1, 1'b1, 1'b0, 32'h0040_0103);
    dslot("jr_ds", 32'h0040_0018);

    // Stall for five cycles in EXEC
    check("stl:addr", imem_addr, 32'h0040_0100);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stl:instr", instr, 32'h1234_5678);
      check("stl:pc",    pc, 32'h0040_0100);
      check("stl:icnt",  icount, exp_icount);
      check("stl:req",   {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    exp_icount++;
    check("stl:ret_icnt",  icount, exp_icount);
    check("stl:ret_req",   {31'b0, imem_req}, 32'd1);
    check("stl:ret_valid", {31'b0, instr_valid}, 32'd0);
    check("stl:ret_addr",  imem_addr, 32'h0040_0104);

    // Address wrap at the top of the space
    step("jr_top", 32'h0040_0104, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    dslot("top_ds", 32'h0040_0108);
    step("top",    32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    step("wrap",   32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset during a fetch with the ack held off
    @(negedge clk);
    check("mid:req", {31'b0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("mid");
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("late:valid", {31'b0, instr_valid}, 32'd0);
    check("late:instr", instr, 32'h0);
    check("late:addr",  imem_addr, RST_PC);
    exp_icount = 32'h0;
    step("restart", 32'h0040_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0);
    check("restart:next", imem_addr, 32'h0040_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
